udp_rx: RTL and testbench

- Receive-side counterpart of the UDP encapsulator.
- Accepts a byte-wide AXI-Stream UDP datagram (header plus payload) from the IP RX path.
- Strips the 8-byte UDP header and presents source port, destination port, length and checksum on a valid/ready header port.
- Forwards the payload on an AXI-Stream master with one register stage, and flags truncated headers and length mismatches.

---
 rtl/udp_rx.sv | 154 +++++++++++++++
 tb/tb_udp_rx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx.sv
// UDP receive parser: strips the 8-byte header onto a valid/ready header port
// and forwards the payload through a single output register stage.
module udp_rx #(
  parameter int AXI_DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [AXI_DATA_WIDTH-1:0] s_rx_axis_tdata,
  input  logic                      s_rx_axis_tvalid,
  input  logic                      s_rx_axis_tlast,
  output logic                      s_rx_axis_trdy,
  output logic                      m_udp_hdr_tvalid,
  input  logic                      m_udp_hdr_trdy,
  output logic [15:0]               m_udp_src_port,
  output logic [15:0]               m_udp_dst_port,
  output logic [15:0]               m_udp_length,
  output logic [15:0]               m_udp_checksum,
  output logic [AXI_DATA_WIDTH-1:0] m_rx_axis_tdata,
  output logic                      m_rx_axis_tvalid,
  output logic                      m_rx_axis_tlast,
  input  logic                      m_rx_axis_trdy,
  output logic                      o_hdr_err,
  output logic                      o_len_err
);

  generate
    if (AXI_DATA_WIDTH != 8) begin : g_width_check
      $error("udp_rx supports AXI_DATA_WIDTH = 8 only");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t      state_r;
  logic [2:0]  hdr_cnt_r;
  logic [15:0] pay_cnt_r;
  logic [15:0] src_sh_r;
  logic [15:0] dst_sh_r;
  logic [15:0] len_sh_r;
  logic [7:0]  ck_hi_r;
  logic        run_r;
  logic        rdy_s;
  logic        acc_s;
  logic [15:0] pay_cnt_nxt_s;
  logic        len_bad_s;

  // Input ready and length check derived from the current parse position.
  always_comb begin
    rdy_s = 1'b0;
    case (state_r)
      ST_HDR: begin
        // Byte 7 publishes a header, so it waits for the header slot to free up.
        if (hdr_cnt_r == 3'd7) begin
          rdy_s = !m_udp_hdr_tvalid | m_udp_hdr_trdy;
        end else begin
          rdy_s = 1'b1;
        end
      end
      ST_PAYLOAD: rdy_s = !m_rx_axis_tvalid | m_rx_axis_trdy;
      default:    rdy_s = 1'b0;
    endcase
    pay_cnt_nxt_s = (pay_cnt_r == 16'hFFFF) ? 16'hFFFF : (pay_cnt_r + 16'd1);
    len_bad_s     = (pay_cnt_nxt_s == 16'hFFFF) | ((pay_cnt_nxt_s + 16'd8) != len_sh_r);
  end

  // run_r holds ready low in reset and for the first cycle after release.
  assign s_rx_axis_trdy = run_r & rdy_s;
  assign acc_s          = s_rx_axis_tvalid & s_rx_axis_trdy;

  // Parser state machine with all registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r          <= ST_HDR;
      hdr_cnt_r        <= 3'd0;
      pay_cnt_r        <= 16'd0;
      src_sh_r         <= 16'd0;
      dst_sh_r         <= 16'd0;
      len_sh_r         <= 16'd0;
      ck_hi_r          <= 8'd0;
      run_r            <= 1'b0;
      m_udp_hdr_tvalid <= 1'b0;
      m_udp_src_port   <= 16'd0;
      m_udp_dst_port   <= 16'd0;
      m_udp_length     <= 16'd0;
      m_udp_checksum   <= 16'd0;
      m_rx_axis_tdata  <= '0;
      m_rx_axis_tvalid <= 1'b0;
      m_rx_axis_tlast  <= 1'b0;
      o_hdr_err        <= 1'b0;
      o_len_err        <= 1'b0;
    end else begin
      run_r     <= 1'b1;
      o_hdr_err <= 1'b0;
      o_len_err <= 1'b0;
      if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
        m_udp_hdr_tvalid <= 1'b0;
      end
      if (m_rx_axis_tvalid && m_rx_axis_trdy) begin
        m_rx_axis_tvalid <= 1'b0;
      end
      if (acc_s) begin
        case (state_r)
          ST_HDR: begin
            hdr_cnt_r <= hdr_cnt_r + 3'd1;
            case (hdr_cnt_r)
              3'd0: src_sh_r[15:8] <= s_rx_axis_tdata;
              3'd1: src_sh_r[7:0]  <= s_rx_axis_tdata;
              3'd2: dst_sh_r[15:8] <= s_rx_axis_tdata;
              3'd3: dst_sh_r[7:0]  <= s_rx_axis_tdata;
              3'd4: len_sh_r[15:8] <= s_rx_axis_tdata;
              3'd5: len_sh_r[7:0]  <= s_rx_axis_tdata;
              3'd6: ck_hi_r        <= s_rx_axis_tdata;
              3'd7: begin
                m_udp_src_port   <= src_sh_r;
                m_udp_dst_port   <= dst_sh_r;
                m_udp_length     <= len_sh_r;
                m_udp_checksum   <= {ck_hi_r, s_rx_axis_tdata};
                m_udp_hdr_tvalid <= 1'b1;
              end
              default: ;
            endcase
            if (s_rx_axis_tlast) begin
              hdr_cnt_r <= 3'd0;
              if (hdr_cnt_r == 3'd7) begin
                o_len_err <= (len_sh_r != 16'd8);
              end else begin
                o_hdr_err <= 1'b1;
              end
            end else if (hdr_cnt_r == 3'd7) begin
              state_r   <= ST_PAYLOAD;
              pay_cnt_r <= 16'd0;
            end
          end
          ST_PAYLOAD: begin
            m_rx_axis_tdata  <= s_rx_axis_tdata;
            m_rx_axis_tlast  <= s_rx_axis_tlast;
            m_rx_axis_tvalid <= 1'b1;
            pay_cnt_r        <= pay_cnt_nxt_s;
            if (s_rx_axis_tlast) begin
              state_r   <= ST_HDR;
              hdr_cnt_r <= 3'd0;
              o_len_err <= len_bad_s;
            end
          end
          default: state_r <= ST_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
// Self-checking bench for udp_rx: packet-level reference model with queues,
// directed datagrams from the test plan, then randomized traffic.
module tb_udp_rx;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic [7:0]  s_rx_axis_tdata = 8'd0;
  logic        s_rx_axis_tvalid = 1'b0;
  logic        s_rx_axis_tlast = 1'b0;
  logic        s_rx_axis_trdy;
  logic        m_udp_hdr_tvalid;
  logic        m_udp_hdr_trdy = 1'b1;
  logic [15:0] m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum;
  logic [7:0]  m_rx_axis_tdata;
  logic        m_rx_axis_tvalid, m_rx_axis_tlast;
  logic        m_rx_axis_trdy = 1'b1;
  logic        o_hdr_err, o_len_err;

  udp_rx #(.AXI_DATA_WIDTH(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s_rx_axis_tdata(s_rx_axis_tdata), .s_rx_axis_tvalid(s_rx_axis_tvalid),
    .s_rx_axis_tlast(s_rx_axis_tlast), .s_rx_axis_trdy(s_rx_axis_trdy),
    .m_udp_hdr_tvalid(m_udp_hdr_tvalid), .m_udp_hdr_trdy(m_udp_hdr_trdy),
    .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
    .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
    .m_rx_axis_tdata(m_rx_axis_tdata), .m_rx_axis_tvalid(m_rx_axis_tvalid),
    .m_rx_axis_tlast(m_rx_axis_tlast), .m_rx_axis_trdy(m_rx_axis_trdy),
    .o_hdr_err(o_hdr_err), .o_len_err(o_len_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int gap_pct = 0;
  int hold_until = 0;
  int cur_idx = -1;
  logic lat_check = 1'b0;
  logic stall_seen = 1'b0;

  logic [7:0]  pkt[$];
  logic [8:0]  exp_pay_q[$];
  logic [63:0] exp_hdr_q[$];
  logic [1:0]  exp_err_q[$];
  int          lat_q[$];

  logic pend_hdr = 1'b0, pend_len = 1'b0;
  logic prev_pay_hold = 1'b0, prev_hdr_hold = 1'b0;
  logic [8:0]  prev_pay = 9'd0;
  logic [63:0] prev_hdr = 64'd0;
  logic [63:0] last_hdr = 64'd0;
  int len_err_seen = 0, hdr_err_seen = 0, hdr_seen = 0, pay_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what one datagram must produce, from the byte list alone.
  task automatic expect_pkt();
    int n;
    logic [15:0] tot;
    n = pkt.size();
    if (n < 8) begin
      exp_err_q.push_back(2'b10);
    end else begin
      exp_hdr_q.push_back({pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5], pkt[6], pkt[7]});
      for (int i = 8; i < n; i++) exp_pay_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, pkt[i]});
      tot = 16'(n - 8 + 8);
      exp_err_q.push_back({1'b0, (tot != {pkt[4], pkt[5]}) ? 1'b1 : 1'b0});
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Output-ready patterns.
  initial forever begin
    @(posedge i_clk);
    #1;
    case (mode)
      0: begin m_rx_axis_trdy = 1'b1; m_udp_hdr_trdy = 1'b1; end
      1: begin
        m_rx_axis_trdy = ($urandom_range(99) < 70);
        m_udp_hdr_trdy = ($urandom_range(99) < 60);
      end
      2: begin
        m_rx_axis_trdy = !m_rx_axis_trdy;
        m_udp_hdr_trdy = (cyc >= hold_until);
      end
      default: begin m_rx_axis_trdy = 1'b1; m_udp_hdr_trdy = 1'b1; end
    endcase
  end

  // Single compare process, sampling on the falling edge.
  initial forever begin
    @(negedge i_clk);
    if (!i_reset_n) begin
      pend_hdr = 1'b0; pend_len = 1'b0;
      prev_pay_hold = 1'b0; prev_hdr_hold = 1'b0;
    end else begin
      chk("hdr_err_pulse", o_hdr_err, pend_hdr);
      chk("len_err_pulse", o_len_err, pend_len);
      if (o_hdr_err) hdr_err_seen++;
      if (o_len_err) len_err_seen++;
      if (prev_pay_hold) chk("pay_stable", {m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tdata}, {1'b1, prev_pay});
      if (prev_hdr_hold)
        chk("hdr_stable", {m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum} , {1'b1, prev_hdr});
      if (m_rx_axis_tvalid && m_rx_axis_trdy) begin
        pay_seen++;
        if (exp_pay_q.size() == 0) chk("pay_unexpected", 64'd1, 64'd0);
        else chk("pay_beat", {m_rx_axis_tlast, m_rx_axis_tdata}, exp_pay_q.pop_front());
        if (lat_q.size() != 0) begin
          int l;
          l = lat_q.pop_front();
          if (lat_check) chk("pay_latency", cyc, l + 1);
        end
      end
      if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
        hdr_seen++;
        last_hdr = {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum};
        if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 64'd1, 64'd0);
        else chk("hdr_fields", last_hdr, exp_hdr_q.pop_front());
      end
      pend_hdr = 1'b0; pend_len = 1'b0;
      if (s_rx_axis_tvalid && s_rx_axis_trdy) begin
        if (cur_idx >= 8) lat_q.push_back(cyc);
        if (s_rx_axis_tlast) begin
          if (exp_err_q.size() == 0) chk("tlast_unexpected", 64'd1, 64'd0);
          else {pend_hdr, pend_len} = exp_err_q.pop_front();
        end
      end
      prev_pay_hold = m_rx_axis_tvalid && !m_rx_axis_trdy;
      prev_pay = {m_rx_axis_tlast, m_rx_axis_tdata};
      prev_hdr_hold = m_udp_hdr_tvalid && !m_udp_hdr_trdy;
      prev_hdr = {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum};
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {s_rx_axis_trdy, m_udp_hdr_tvalid, m_rx_axis_tvalid, m_rx_axis_tlast,
                         o_hdr_err, o_len_err, m_rx_axis_tdata}, 64'd0);
    chk({tag, "_hdr"}, {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum}, 64'd0);
  endtask

  task automatic do_reset();
    #3;
    i_reset_n = 1'b0;
    #1;
    check_zero("rst_async");
    s_rx_axis_tvalid = 1'b0;
    s_rx_axis_tlast = 1'b0;
    cur_idx = -1;
    exp_pay_q.delete(); exp_hdr_q.delete(); exp_err_q.delete(); lat_q.delete();
    repeat (2) @(posedge i_clk);
    #2;
    i_reset_n = 1'b1;
  endtask

  task automatic send_pkt(input int abort_idx);
    logic acc;
    int waited;
    expect_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_rx_axis_tvalid = 1'b0;
        @(posedge i_clk); #1;
      end
      s_rx_axis_tdata = pkt[i];
      s_rx_axis_tlast = (i == pkt.size() - 1);
      s_rx_axis_tvalid = 1'b1;
      cur_idx = i;
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge i_clk);
        acc = s_rx_axis_trdy;
        if (i == 7) begin
          chk("byte7_rdy", s_rx_axis_trdy, !m_udp_hdr_tvalid | m_udp_hdr_trdy);
          if (!s_rx_axis_trdy) stall_seen = 1'b1;
        end
        @(posedge i_clk); #1;
        waited++;
        if (!acc && waited > 2000) begin
          chk("handshake_timeout", 64'd0, 64'd1);
          s_rx_axis_tvalid = 1'b0;
          cur_idx = -1;
          return;
        end
      end
      if (i == abort_idx) begin
        do_reset();
        return;
      end
    end
    s_rx_axis_tvalid = 1'b0;
    s_rx_axis_tlast = 1'b0;
    cur_idx = -1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_pay_q.size() + exp_hdr_q.size() + exp_err_q.size()) != 0 && w < 1000) begin
      @(posedge i_clk);
      w++;
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk("drain_empty", exp_pay_q.size() + exp_hdr_q.size() + exp_err_q.size(), 64'd0);
  endtask

  task automatic load_base(input logic [15:0] len);
    pkt = '{8'h12, 8'h34, 8'h56, 8'h78, len[15:8], len[7:0], 8'hDE, 8'hAD,
            8'hAA, 8'hBB, 8'hCC, 8'hDD};
  endtask

  initial begin
    int b_len, b_hdr_err, b_hdr, b_pay, n, pay;
    #2 i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero("rst_init");
    @(posedge i_clk); #2;
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk); #1;

    // Reference datagram, continuous ready, 1-cycle latency checked.
    lat_check = 1'b1;
    b_len = len_err_seen; b_pay = pay_seen;
    load_base(16'h000C); send_pkt(-1); drain();
    chk("p1_hdr", last_hdr, 64'h1234_5678_000C_DEAD);
    chk("p1_pay_cnt", pay_seen - b_pay, 64'd4);
    chk("p1_no_len_err", len_err_seen - b_len, 64'd0);

    // Wrong length field.
    b_len = len_err_seen; b_pay = pay_seen;
    load_base(16'h0010); send_pkt(-1); drain();
    chk("p2_len_err", len_err_seen - b_len, 64'd1);
    chk("p2_pay_cnt", pay_seen - b_pay, 64'd4);
    chk("p2_hdr", last_hdr, 64'h1234_5678_0010_DEAD);

    // Truncated header followed by a good datagram.
    b_hdr_err = hdr_err_seen; b_hdr = hdr_seen; b_pay = pay_seen;
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; send_pkt(-1);
    load_base(16'h000C); send_pkt(-1); drain();
    chk("p3_hdr_err", hdr_err_seen - b_hdr_err, 64'd1);
    chk("p3_hdr_cnt", hdr_seen - b_hdr, 64'd1);
    chk("p3_pay_cnt", pay_seen - b_pay, 64'd4);
    chk("p3_hdr", last_hdr, 64'h1234_5678_000C_DEAD);

    // Header only.
    b_len = len_err_seen; b_hdr = hdr_seen; b_pay = pay_seen;
    pkt = '{8'hC0, 8'h01, 8'h00, 8'h35, 8'h00, 8'h08, 8'h12, 8'h34}; send_pkt(-1); drain();
    chk("p4_hdr", last_hdr, 64'hC001_0035_0008_1234);
    chk("p4_hdr_cnt", hdr_seen - b_hdr, 64'd1);
    chk("p4_pay_cnt", pay_seen - b_pay, 64'd0);
    chk("p4_no_len_err", len_err_seen - b_len, 64'd0);
    lat_check = 1'b0;

    // Toggling payload ready, header ready held low for 20 cycles.
    mode = 2; hold_until = cyc + 20; stall_seen = 1'b0; b_pay = pay_seen;
    pkt = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h00, 8'h09, 8'h33, 8'h33, 8'h5A}; send_pkt(-1);
    pkt = '{8'h44, 8'h44, 8'h55, 8'h55, 8'h00, 8'h0D, 8'h66, 8'h66,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(-1); drain();
    chk("p5_stall_byte7", stall_seen, 64'd1);
    chk("p5_pay_cnt", pay_seen - b_pay, 64'd6);
    chk("p5_hdr", last_hdr, 64'h4444_5555_000D_6666);

    // Asynchronous reset after payload byte 2, then a clean datagram.
    mode = 0;
    repeat (3) @(posedge i_clk); #1;
    load_base(16'h000C); send_pkt(10);
    repeat (2) @(posedge i_clk); #1;
    b_pay = pay_seen;
    load_base(16'h000C); send_pkt(-1); drain();
    chk("p6_hdr", last_hdr, 64'h1234_5678_000C_DEAD);
    chk("p6_pay_cnt", pay_seen - b_pay, 64'd4);

    // Randomized traffic.
    mode = 1; gap_pct = 30;
    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      case ($urandom_range(9))
        0: n = $urandom_range(7, 1);
        1: n = 8;
        default: n = 8 + $urandom_range(24, 1);
      endcase
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(255)));
      if (n >= 8 && $urandom_range(4) != 0) begin
        pay = n;
        pkt[4] = 8'(pay >> 8);
        pkt[5] = 8'(pay);
      end
      send_pkt(-1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
